// File: rtl/fc_pkg.sv
// Shared FC-layer constants and the score buffer state encoding.
// Imported by the score buffer, its interface and the FC top level.
package fc_pkg;

  localparam int FC_N_SCORES = 10;
  localparam int FC_SCORE_W  = 16;
  localparam int FC_COUNT_W  = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } sb_state_e;

endpackage

// File: rtl/score_buffer_if.sv
// Score stream in, buffered frame out; master is the producer/consumer side,
// slave is the score buffer itself.
interface score_buffer_if import fc_pkg::*; #(
  parameter int N_SCORES = FC_N_SCORES,
  parameter int SCORE_W  = FC_SCORE_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [SCORE_W-1:0]    in_data;
  logic                  in_last;
  logic [SCORE_W-1:0]    outing2 [N_SCORES];
  logic                  max;
  logic                  frame_valid;
  logic                  frame_ack;
  logic [FC_COUNT_W-1:0] count;
  logic                  err_short;

  modport master (
    output in_valid, in_data, in_last, frame_ack,
    input  in_ready, outing2, max, frame_valid, count, err_short
  );

  modport slave (
    input  in_valid, in_data, in_last, frame_ack,
    output in_ready, outing2, max, frame_valid, count, err_short
  );

endinterface

// File: rtl/score_buffer.sv
// Collects N_SCORES FC output scores into a frame buffer and hands the frame
// to a downstream consumer through a toggle trigger plus a valid/ack pair.
module score_buffer import fc_pkg::*; #(
  parameter int N_SCORES = FC_N_SCORES,
  parameter int SCORE_W  = FC_SCORE_W
) (
  input  logic          clk,
  input  logic          rst,
  score_buffer_if.slave sb
);

  localparam logic [FC_COUNT_W-1:0] LAST_IDX = FC_COUNT_W'(N_SCORES - 1);

  sb_state_e             state_q;
  logic [FC_COUNT_W-1:0] count_q;
  logic [SCORE_W-1:0]    buf_q [N_SCORES];
  logic                  max_q;
  logic                  frame_valid_q;
  logic                  err_short_q;

  // Frame fill / hold state machine with all outputs held in registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      count_q       <= '0;
      buf_q         <= '{default: '0};
      max_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (sb.in_valid) begin
            buf_q[count_q] <= sb.in_data;
            // A full frame wins over in_last, so last-on-final-beat is a normal completion.
            if (count_q == LAST_IDX) begin
              state_q       <= HOLD;
              frame_valid_q <= 1'b1;
              max_q         <= ~max_q;
              count_q       <= '0;
            end else if (sb.in_last) begin
              err_short_q <= 1'b1;
              count_q     <= '0;
            end else begin
              count_q <= count_q + FC_COUNT_W'(1);
            end
          end
        end
        HOLD: begin
          // Buffer contents survive the release; new beats overwrite them.
          if (sb.frame_ack) begin
            state_q       <= FILL;
            frame_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign sb.in_ready    = (state_q == FILL);
  assign sb.outing2     = buf_q;
  assign sb.max         = max_q;
  assign sb.frame_valid = frame_valid_q;
  assign sb.count       = count_q;
  assign sb.err_short   = err_short_q;

endmodule

// File: tb/tb_score_buffer.sv
// Self-checking bench for score_buffer: directed scenarios plus random traffic,
// all compared each cycle against a frame-level reference model.
module tb_score_buffer;

  localparam int N  = 10;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_buffer_if #(.N_SCORES(N), .SCORE_W(SW)) sb ();

  score_buffer #(.N_SCORES(N), .SCORE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the frame being collected as a queue of scores.
  logic [SW-1:0] m_frame [$];
  logic [SW-1:0] m_buf [N];
  bit            m_hold;
  int            m_frames;
  bit            m_err;

  int max_edges = 0;
  always @(sb.max) max_edges++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    for (int i = 0; i < N; i++) m_buf[i] = '0;
    m_hold   = 1'b0;
    m_frames = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    m_err = 1'b0;
    if (!m_hold) begin
      if (sb.in_valid) begin
        m_buf[m_frame.size()] = sb.in_data;
        m_frame.push_back(sb.in_data);
        if (m_frame.size() == N) begin
          m_hold = 1'b1;
          m_frames++;
          m_frame.delete();
        end else if (sb.in_last) begin
          m_err = 1'b1;
          m_frame.delete();
        end
      end
    end else if (sb.frame_ack) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ":in_ready"},    32'(sb.in_ready),    32'(!m_hold));
    check_eq({ctx, ":frame_valid"}, 32'(sb.frame_valid), 32'(m_hold));
    check_eq({ctx, ":max"},         32'(sb.max),         32'(m_frames % 2));
    check_eq({ctx, ":count"},       32'(sb.count),       32'(m_frame.size()));
    check_eq({ctx, ":err_short"},   32'(sb.err_short),   32'(m_err));
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s:outing2[%0d]", ctx, i), 32'(sb.outing2[i]), 32'(m_buf[i]));
  endtask

  task automatic drive(input bit v, input logic [SW-1:0] d, input bit l, input bit a);
    sb.in_valid  = v;
    sb.in_data   = d;
    sb.in_last   = l;
    sb.frame_ack = a;
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(ctx);
  endtask

  logic [SW-1:0] set_b [N];
  int e0;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    model_reset();
    check_all("reset");
    #2 rst = 1'b0;

    // Basic frame 1..10 back to back
    for (int k = 1; k <= N; k++) begin
      drive(1'b1, SW'(k), 1'b0, 1'b0);
      step("basic");
    end
    check_eq("basic_fv",       32'(sb.frame_valid), 32'd1);
    check_eq("basic_max",      32'(sb.max),         32'd1);
    check_eq("basic_out9",     32'(sb.outing2[9]),  32'd10);
    check_eq("basic_in_ready", 32'(sb.in_ready),    32'd0);

    // Backpressure: valid held through HOLD, then ack with valid still high
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'd77, 1'b0, 1'b0);
      step("bp_hold");
    end
    drive(1'b1, 16'd77, 1'b0, 1'b1);
    step("bp_ack");
    check_eq("bp_ack_count", 32'(sb.count), 32'd0);
    drive(1'b1, 16'd88, 1'b0, 1'b0);
    step("bp_accept");
    check_eq("bp_count", 32'(sb.count),      32'd1);
    check_eq("bp_out0",  32'(sb.outing2[0]), 32'd88);
    for (int k = 0; k < N - 1; k++) begin
      drive(1'b1, SW'(200 + k), 1'b0, 1'b0);
      step("bp_fill");
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step("bp_release");

    // Short frame: in_last on the 4th beat
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, SW'(300 + k), (k == 3), 1'b0);
      step("short");
    end
    check_eq("short_err",   32'(sb.err_short),   32'd1);
    check_eq("short_count", 32'(sb.count),       32'd0);
    check_eq("short_fv",    32'(sb.frame_valid), 32'd0);
    check_eq("short_max",   32'(sb.max),         32'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    step("short_idle");
    check_eq("short_err_gone", 32'(sb.err_short), 32'd0);

    // Two consecutive frames: one max edge each
    e0 = max_edges;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, SW'($urandom), 1'b0, 1'b0);
      step("two_a");
    end
    check_eq("two_a_max",   32'(sb.max),         32'd1);
    check_eq("two_a_edges", 32'(max_edges - e0), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    step("two_ack");
    for (int k = 0; k < N; k++) begin
      set_b[k] = SW'($urandom);
      drive(1'b1, set_b[k], 1'b0, 1'b0);
      step("two_b");
    end
    check_eq("two_b_max",   32'(sb.max),         32'd0);
    check_eq("two_b_edges", 32'(max_edges - e0), 32'd2);
    for (int k = 0; k < N; k++)
      check_eq($sformatf("two_b_out[%0d]", k), 32'(sb.outing2[k]), 32'(set_b[k]));
    drive(1'b0, '0, 1'b0, 1'b1);
    step("two_release");

    // Reset between clock edges after 6 beats
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, SW'(400 + k), 1'b0, 1'b0);
      step("rst_fill");
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    check_eq("rst_count", 32'(sb.count),      32'd0);
    check_eq("rst_out0",  32'(sb.outing2[0]), 32'd0);
    step("rst_held");
    #2 rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      set_b[k] = SW'($urandom);
      drive(1'b1, set_b[k], 1'b0, 1'b0);
      step("rst_clean");
    end
    check_eq("rst_clean_fv",  32'(sb.frame_valid), 32'd1);
    check_eq("rst_clean_max", 32'(sb.max),         32'd1);
    for (int k = 0; k < N; k++)
      check_eq($sformatf("rst_clean_out[%0d]", k), 32'(sb.outing2[k]), 32'(set_b[k]));
    drive(1'b0, '0, 1'b0, 1'b1);
    step("rst_release");

    // Gapped input: valid toggling 1/0
    for (int k = 0; k < 2 * N; k++) begin
      drive(~k[0], SW'(500 + k), 1'b0, 1'b0);
      step("gap");
    end
    check_eq("gap_fv", 32'(sb.frame_valid), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);
    step("gap_release");

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(99) < 70), SW'($urandom), ($urandom_range(99) < 5),
            ($urandom_range(99) < 30));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
